jogada_round_timer: RTL
=======================

# jogada_round_timer

Round-timing stage that sits directly upstream of the random LED controller. It produces the per-round game counter `contador_jogo`, the colour thresholds `mid_idx`/`max_idx` for the selected difficulty, the `gerar_jogada` request that loads a new LED frame, and the mid-round `trigger` used to start the fader. It also judges each player response as a hit or a timeout and tracks round progress up to end of game.

## Interface
Parameters:
- `N`, 29: counter/threshold width.
- `T0`, 150_000_000: round length in cycles, level 0.
- `T1`, 100_000_000: round length in cycles, level 1.
- `T2`, 50_000_000: round length in cycles, level 2.
- `T3`, 75_000_000: round length in cycles, level 3 (faded mode).
- `GAP`, 25_000_000: idle cycles between rounds.
- `RODADAS`, 10: hits needed to win.

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: asynchronous, active-high; all state cleared.
- `iniciar` in 1: start or restart request, one-cycle pulse.
- `jogada_feita` in 1: player response, one-cycle pulse.
- `nivel_dificuldade` in 2: difficulty; sampled only on entry to PREPARA.
- `contador_jogo` out N: cycles elapsed in current round.
- `mid_idx` out N: `max_idx >> 1`.
- `max_idx` out N: last count of the current round (T_level − 1).
- `gerar_jogada` out 1: one-cycle new-round pulse.
- `trigger` out 1: one-cycle mid-round pulse.
- `acerto` out 1: one-cycle hit pulse.
- `timeout` out 1: one-cycle miss pulse.
- `tempo_resposta` out N: `contador_jogo` value at the last hit.
- `rodada` out 8: hits so far in the current game.
- `rodada_ativa` out 1: high in CONTA.
- `fim_jogo` out 1: high in FIM.
- `vitoria` out 1: in FIM, 1 = won, 0 = timed out.

## Operation
- FSM states: IDLE, PREPARA, CONTA, ESPERA, FIM.
- IDLE:
  - `iniciar` → PREPARA.
  - Other inputs are ignored.
- Entering PREPARA (from IDLE, FIM or ESPERA), all on the same edge:
  - `max_idx` ← T_level − 1 and `mid_idx` ← (T_level − 1) >> 1.
  - `contador_jogo` ← 0.
  - From IDLE/FIM only: `rodada` ← 0 and `vitoria` ← 0.
- PREPARA lasts exactly 1 cycle with `gerar_jogada` = 1, then → CONTA.
- CONTA: `contador_jogo` increments by 1 per cycle. Evaluated in priority order:
  - `jogada_feita` = 1 (takes priority, even when `contador_jogo` == `max_idx`):
    - `tempo_resposta` ← `contador_jogo`; `rodada` ← `rodada` + 1; `acerto` pulses the next cycle.
    - Next state is FIM with `vitoria` ← 1 if `rodada` + 1 == RODADAS, otherwise ESPERA.
    - `contador_jogo` does not increment on that edge.
  - Else if `contador_jogo` == `max_idx`: `timeout` pulses the next cycle; → FIM with `vitoria` = 0; the counter holds.
- `trigger` = (state == CONTA) && (`contador_jogo` == `mid_idx`). It is exactly one cycle per round, and it is suppressed if the round ended earlier.
- ESPERA: a gap counter runs GAP cycles; then → PREPARA, sampling the level anew. `contador_jogo` holds its value.
- FIM: all outputs hold.
  - `iniciar` → PREPARA (new game).
  - `jogada_feita` is ignored.
- `iniciar` in PREPARA, CONTA or ESPERA is ignored.
- A level change mid-round takes effect only at the next PREPARA.
- `rodada` saturates at 255.
- Arithmetic is unsigned N-bit. T_level must be ≥ 2.

## Timing
- Reset values: state IDLE; every output 0, including `max_idx`, `mid_idx` and `tempo_resposta`.
- Reset mid-round aborts immediately, with no pulse emitted.
- Latencies:
  - `iniciar` at edge k → `gerar_jogada` high during cycle k+1.
  - `contador_jogo` = 0 in cycle k+2, the first CONTA cycle.
- A round with no response lasts T_level CONTA cycles (0..T−1); `timeout` is high the cycle after `contador_jogo` = T−1.
- `acerto` and `timeout` are registered one-cycle pulses that never coincide.
- Between consecutive rounds: ESPERA lasts GAP cycles and PREPARA 1 cycle; `gerar_jogada` is never high in two consecutive cycles.
- `max_idx` and `mid_idx` are stable from the `gerar_jogada` cycle until the next PREPARA entry.

## Test plan
Parameters for all scenarios: T0=20, T1=16, T2=12, T3=8, GAP=4, RODADAS=3.
- Reset, then `iniciar` with level 2:
  - `gerar_jogada` one cycle later, with `max_idx` = 11 and `mid_idx` = 5.
  - `trigger` when the counter is 5.
  - No response: `timeout` after counter 11; `fim_jogo` = 1, `vitoria` = 0.
- Level 0, `jogada_feita` at counter 7:
  - `acerto` pulse, `tempo_resposta` = 7, `rodada` = 1.
  - 4 ESPERA cycles, then `gerar_jogada` again.
- Three hits at level 3:
  - `trigger` at counter 3 each round.
  - After the third hit: `fim_jogo` = 1, `vitoria` = 1, `rodada` = 3.
  - A following `iniciar` clears `rodada` to 0.
- `jogada_feita` in the same cycle as counter == `max_idx` → counted as `acerto`, no `timeout`.
- Level changed 1→2 during CONTA → `max_idx` stays 15 for that round and becomes 11 at the next `gerar_jogada`.
- `reset` asserted at counter 6 → all outputs 0 immediately; `iniciar` ignored while `reset` is high; normal start after release.

Source files
------------

// File: rtl/jogada_round_timer_if.sv
// Bundle of control inputs and round-status outputs for jogada_round_timer.
// Latency: none, plain wiring between the driver and the timer.
// Backpressure: none; every signal is a level or a one-cycle pulse.
interface jogada_round_timer_if #(
  parameter int N = 29
);
  logic         iniciar;
  logic         jogada_feita;
  logic [1:0]   nivel_dificuldade;
  logic [N-1:0] contador_jogo;
  logic [N-1:0] mid_idx;
  logic [N-1:0] max_idx;
  logic         gerar_jogada;
  logic         trigger;
  logic         acerto;
  logic         timeout;
  logic [N-1:0] tempo_resposta;
  logic [7:0]   rodada;
  logic         rodada_ativa;
  logic         fim_jogo;
  logic         vitoria;

  // Game controller side: issues start/response/level, observes status.
  modport master (
    output iniciar, jogada_feita, nivel_dificuldade,
    input  contador_jogo, mid_idx, max_idx, gerar_jogada, trigger,
    input  acerto, timeout, tempo_resposta, rodada, rodada_ativa,
    input  fim_jogo, vitoria
  );

  // Timer side.
  modport slave (
    input  iniciar, jogada_feita, nivel_dificuldade,
    output contador_jogo, mid_idx, max_idx, gerar_jogada, trigger,
    output acerto, timeout, tempo_resposta, rodada, rodada_ativa,
    output fim_jogo, vitoria
  );
endinterface

// File: rtl/jogada_round_timer.sv
// Round timer: counts each round, emits new-frame/mid-round pulses, judges hit or timeout.
// Latency: iniciar -> gerar_jogada next cycle; acerto/timeout one cycle after the deciding edge.
// Backpressure: none; pulses are fire-and-forget, inputs outside their window are ignored.
module jogada_round_timer #(
  parameter int N       = 29,
  parameter int T0      = 150_000_000,
  parameter int T1      = 100_000_000,
  parameter int T2      = 50_000_000,
  parameter int T3      = 75_000_000,
  parameter int GAP     = 25_000_000,
  parameter int RODADAS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  jogada_round_timer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREPARA = 3'd1,
    CONTA   = 3'd2,
    ESPERA  = 3'd3,
    FIM     = 3'd4
  } state_t;

  localparam logic [N-1:0] LAST0    = N'(T0 - 1);
  localparam logic [N-1:0] LAST1    = N'(T1 - 1);
  localparam logic [N-1:0] LAST2    = N'(T2 - 1);
  localparam logic [N-1:0] LAST3    = N'(T3 - 1);
  localparam logic [31:0]  GAP_LAST = 32'(GAP - 1);
  localparam logic [8:0]   WIN_CNT  = 9'(RODADAS);

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] contador;
  logic [N-1:0] mid_q;
  logic [N-1:0] max_q;
  logic [N-1:0] tempo_q;
  logic [7:0]   rodada_q;
  logic         acerto_q;
  logic         timeout_q;
  logic         vitoria_q;
  logic [31:0]  gap_cnt;

  logic [N-1:0] lvl_last;
  logic [7:0]   rodada_sat;
  logic         win;
  logic         enter_prep;
  logic         new_game;
  logic         gerar_c;
  logic         trigger_c;
  logic         ativa_c;
  logic         fim_c;

  // Last count of a round for the currently requested difficulty.
  always_comb begin
    lvl_last = LAST0;
    case (bus.nivel_dificuldade)
      2'd0:    lvl_last = LAST0;
      2'd1:    lvl_last = LAST1;
      2'd2:    lvl_last = LAST2;
      default: lvl_last = LAST3;
    endcase
  end

  // Hit-count increment saturates so a long game never wraps back to zero.
  assign rodada_sat = (rodada_q == 8'hFF) ? 8'hFF : rodada_q + 8'd1;
  assign win        = (({1'b0, rodada_q} + 9'd1) == WIN_CNT);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and the state-derived status outputs.
  always_comb begin
    state_nxt = state;
    gerar_c   = 1'b0;
    trigger_c = 1'b0;
    ativa_c   = 1'b0;
    fim_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iniciar) state_nxt = PREPARA;
      end
      PREPARA: begin
        gerar_c   = 1'b1;
        state_nxt = CONTA;
      end
      CONTA: begin
        ativa_c   = 1'b1;
        trigger_c = (contador == mid_q);
        // A response on the final count still wins over the timeout.
        if (bus.jogada_feita)      state_nxt = win ? FIM : ESPERA;
        else if (contador == max_q) state_nxt = FIM;
      end
      ESPERA: begin
        if (gap_cnt == GAP_LAST) state_nxt = PREPARA;
      end
      FIM: begin
        fim_c = 1'b1;
        if (bus.iniciar) state_nxt = PREPARA;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_prep = (state_nxt == PREPARA) && (state != PREPARA);
  assign new_game   = enter_prep && ((state == IDLE) || (state == FIM));

  // Round datapath: thresholds, counters, verdict pulses and score.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador  <= '0;
      mid_q     <= '0;
      max_q     <= '0;
      tempo_q   <= '0;
      rodada_q  <= '0;
      acerto_q  <= 1'b0;
      timeout_q <= 1'b0;
      vitoria_q <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      acerto_q  <= 1'b0;
      timeout_q <= 1'b0;

      // Level is latched only here, so mid-round changes wait for the next round.
      if (enter_prep) begin
        max_q    <= lvl_last;
        mid_q    <= lvl_last >> 1;
        contador <= '0;
        if (new_game) begin
          rodada_q  <= '0;
          vitoria_q <= 1'b0;
        end
      end

      if (state == CONTA) begin
        if (bus.jogada_feita) begin
          tempo_q  <= contador;
          rodada_q <= rodada_sat;
          acerto_q <= 1'b1;
          gap_cnt  <= '0;
          if (win) vitoria_q <= 1'b1;
        end else if (contador == max_q) begin
          timeout_q <= 1'b1;
        end else begin
          contador <= contador + N'(1);
        end
      end

      if ((state == ESPERA) && (state_nxt == ESPERA)) gap_cnt <= gap_cnt + 32'd1;
    end
  end

  assign bus.contador_jogo  = contador;
  assign bus.mid_idx        = mid_q;
  assign bus.max_idx        = max_q;
  assign bus.gerar_jogada   = gerar_c;
  assign bus.trigger        = trigger_c;
  assign bus.acerto         = acerto_q;
  assign bus.timeout        = timeout_q;
  assign bus.tempo_resposta = tempo_q;
  assign bus.rodada         = rodada_q;
  assign bus.rodada_ativa   = ativa_c;
  assign bus.fim_jogo       = fim_c;
  assign bus.vitoria        = vitoria_q;

endmodule
